// File: rtl/slice_serial_alu_pkg.sv
// Shared types for the bit-sliced serial ALU.
// Op encodings, FSM state and slice-count helper.
package spar_slice_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_AND = 2'd2,
    OP_XOR = 2'd3
  } op_e;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  function automatic int nslice(
    input int length,
    input int slice_size
  );
    return length / slice_size;
  endfunction

endpackage

// File: rtl/slice_lane_alu.sv
// Combinational one-slice ALU for a single lane.
// Carry passes straight through for the logic ops.
module slice_lane_alu
  import spar_slice_pkg::*;
#(
  parameter int W = 4
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic         i_cin,
  input  op_e          i_op,
  output logic [W-1:0] o_r,
  output logic         o_cout
);

  logic [W-1:0] w_b;
  logic [W:0]   w_sum;

  always_comb begin
    w_b    = (i_op == OP_SUB) ? ~i_b : i_b;
    w_sum  = {1'b0, i_a} + {1'b0, w_b}
           + {{W{1'b0}}, i_cin};
    o_r    = '0;
    o_cout = i_cin;
    unique case (i_op)
      OP_ADD, OP_SUB: begin
        o_r    = w_sum[W-1:0];
        o_cout = w_sum[W];
      end
      OP_AND: o_r = i_a & i_b;
      OP_XOR: o_r = i_a ^ i_b;
      default: begin
        o_r    = '0;
        o_cout = i_cin;
      end
    endcase
  end

endmodule

// File: rtl/slice_serial_alu.sv
// Serial slice ALU lane array: FSM, slice counter and
// per-lane carry / zero tracking around slice_lane_alu.
module slice_serial_alu
  import spar_slice_pkg::*;
#(
  parameter int SIZE       = 1,
  parameter int PE         = 2,
  parameter int Slice_Size = 4,
  parameter int LENGTH     = 32
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [1:0]                    op,
  input  logic                          in_valid,
  input  logic [Slice_Size*PE*2*SIZE-1:0] serial_data_in,
  output logic [Slice_Size*PE*SIZE-1:0] serial_data_out,
  output logic                          out_valid,
  output logic [PE*SIZE-1:0]            carry_out,
  output logic [PE*SIZE-1:0]            zero,
  output logic                          busy,
  output logic                          finish
);

  localparam int L      = PE * SIZE;
  localparam int S      = Slice_Size;
  localparam int NSLICE = nslice(LENGTH, Slice_Size);
  localparam int CW     = $clog2(NSLICE) + 1;
  localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

  state_e          r_state;
  op_e             r_op;
  logic [CW-1:0]   r_cnt;
  logic [L-1:0]    r_carry;
  logic [L-1:0]    r_zacc;
  logic [L*S-1:0]  r_dout;
  logic            r_ovalid;
  logic            r_finish;
  logic [L-1:0]    r_cout;
  logic [L-1:0]    r_zero;

  logic [L*S-1:0]  w_res;
  logic [L-1:0]    w_cy;
  logic [L-1:0]    w_z;

  for (genvar i = 0; i < L; i++) begin : g_lane
    slice_lane_alu #(.W(S)) u_lane (
      .i_a    (serial_data_in[i*2*S +: S]),
      .i_b    (serial_data_in[i*2*S+S +: S]),
      .i_cin  (r_carry[i]),
      .i_op   (r_op),
      .o_r    (w_res[i*S +: S]),
      .o_cout (w_cy[i])
    );
    assign w_z[i] = (w_res[i*S +: S] == '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_op     <= OP_ADD;
      r_cnt    <= '0;
      r_carry  <= '0;
      r_zacc   <= '1;
      r_dout   <= '0;
      r_ovalid <= 1'b0;
      r_finish <= 1'b0;
      r_cout   <= '0;
      r_zero   <= '0;
    end else begin
      r_ovalid <= 1'b0;
      r_finish <= 1'b0;
      if (start) begin
        r_op    <= op_e'(op);
        r_cnt   <= '0;
        r_carry <= {L{op_e'(op) == OP_SUB}};
        r_zacc  <= '1;
        r_cout  <= '0;
        r_zero  <= '0;
        r_state <= ST_RUN;
      end else if (r_state == ST_RUN && in_valid) begin
        r_dout   <= w_res;
        r_ovalid <= 1'b1;
        r_carry  <= w_cy;
        r_zacc   <= r_zacc & w_z;
        r_cnt    <= r_cnt + 1'b1;
        if (r_cnt == LAST) begin
          r_finish <= 1'b1;
          r_cout   <= w_cy;
          r_zero   <= r_zacc & w_z;
          r_state  <= ST_IDLE;
        end
      end
    end
  end

  assign serial_data_out = r_dout;
  assign out_valid       = r_ovalid;
  assign finish          = r_finish;
  assign carry_out       = r_cout;
  assign zero            = r_zero;
  assign busy            = (r_state == ST_RUN);

endmodule

// File: tb/tb_slice_serial_alu.sv
// Scoreboard bench for slice_serial_alu: directed words,
// expected slices queued by stimulus, checked by a monitor.
module tb_slice_serial_alu;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic        in_valid;
  logic [15:0] serial_data_in;
  logic [7:0]  serial_data_out;
  logic        out_valid;
  logic [1:0]  carry_out;
  logic [1:0]  zero;
  logic        busy;
  logic        finish;

  typedef struct {
    logic [7:0] data;
    logic       last;
    logic [1:0] cout;
    logic [1:0] z;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   nfinish = 0;

  always #5 clk = ~clk;

  slice_serial_alu dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .op              (op),
    .in_valid        (in_valid),
    .serial_data_in  (serial_data_in),
    .serial_data_out (serial_data_out),
    .out_valid       (out_valid),
    .carry_out       (carry_out),
    .zero            (zero),
    .busy            (busy),
    .finish          (finish)
  );

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h",
               name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (finish) nfinish++;
    if (out_valid) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out_valid: got 1 expected 0");
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("slice_data", 32'(serial_data_out), 32'(e.data));
        chk("finish_at_slice", 32'(finish), 32'(e.last));
        if (e.last) begin
          chk("carry_out", 32'(carry_out), 32'(e.cout));
          chk("zero", 32'(zero), 32'(e.z));
        end
      end
    end else if (finish) begin
      checks++;
      errors++;
      $display("FAIL finish_without_valid: got 1 expected 0");
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [1:0] o);
    start = 1'b1;
    op    = o;
    in_valid = 1'b0;
    step();
    start = 1'b0;
    chk("busy_after_start", 32'(busy), 32'd1);
    chk("cout_clr_on_start", 32'(carry_out), 32'd0);
    chk("zero_clr_on_start", 32'(zero), 32'd0);
  endtask

  function automatic logic [15:0] pack(
    input logic [31:0] a0, input logic [31:0] b0,
    input logic [31:0] a1, input logic [31:0] b1,
    input int k);
    logic [3:0] sa0, sb0, sa1, sb1;
    sa0 = a0[k*4 +: 4];
    sb0 = b0[k*4 +: 4];
    sa1 = a1[k*4 +: 4];
    sb1 = b1[k*4 +: 4];
    return {sb1, sa1, sb0, sa0};
  endfunction

  task automatic send(
    input logic [31:0] a0, input logic [31:0] b0,
    input logic [31:0] a1, input logic [31:0] b1,
    input logic [31:0] r0, input logic [31:0] r1,
    input logic [1:0] c, input logic [1:0] z,
    input int n, input bit gaps);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      in_valid = 1'b1;
      serial_data_in = pack(a0, b0, a1, b1, k);
      e.data = {r1[k*4 +: 4], r0[k*4 +: 4]};
      e.last = (k == 7);
      e.cout = c;
      e.z    = z;
      q.push_back(e);
      step();
      if (gaps && (k == 2 || k == 5)) begin
        in_valid = 1'b0;
        serial_data_in = 16'hA5A5;
        repeat (3) step();
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (q.size() != 0 && t < 20) begin
      step();
      t++;
    end
    chk("queue_drained", 32'(q.size()), 32'd0);
  endtask

  task automatic word(
    input logic [1:0] o,
    input logic [31:0] a0, input logic [31:0] b0,
    input logic [31:0] a1, input logic [31:0] b1,
    input logic [31:0] r0, input logic [31:0] r1,
    input logic [1:0] c, input logic [1:0] z,
    input bit gaps);
    do_start(o);
    send(a0, b0, a1, b1, r0, r1, c, z, 8, gaps);
    drain();
    repeat (2) step();
    chk("busy_idle", 32'(busy), 32'd0);
    chk("cout_hold", 32'(carry_out), 32'(c));
    chk("zero_hold", 32'(zero), 32'(z));
  endtask

  task automatic all_zero(input string tag);
    chk({tag, "_ovalid"}, 32'(out_valid), 32'd0);
    chk({tag, "_finish"}, 32'(finish), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_cout"}, 32'(carry_out), 32'd0);
    chk({tag, "_zero"}, 32'(zero), 32'd0);
    chk({tag, "_dout"}, 32'(serial_data_out), 32'd0);
  endtask

  initial begin
    int f0;
    reset = 1'b1;
    start = 1'b0;
    op = 2'd0;
    in_valid = 1'b0;
    serial_data_in = '0;
    repeat (3) step();
    reset = 1'b0;
    step();
    all_zero("reset");

    word(2'd0, 32'h0000FFFF, 32'h1, 32'h0000FFFF, 32'h1,
         32'h00010000, 32'h00010000, 2'b00, 2'b00, 1'b0);
    word(2'd1, 32'd5, 32'd7, 32'd5, 32'd7,
         32'hFFFFFFFE, 32'hFFFFFFFE, 2'b00, 2'b00, 1'b0);
    word(2'd1, 32'h12345678, 32'h12345678,
         32'h12345678, 32'h12345678,
         32'h0, 32'h0, 2'b11, 2'b11, 1'b0);
    word(2'd3, 32'hDEADBEEF, 32'hDEADBEEF,
         32'hF0F0F0F0, 32'h0F0F0F0F,
         32'h0, 32'hFFFFFFFF, 2'b00, 2'b01, 1'b0);
    word(2'd2, 32'hF0F0F0F0, 32'hFF00FF00,
         32'h12345678, 32'h0,
         32'hF000F000, 32'h0, 2'b00, 2'b10, 1'b0);

    f0 = nfinish;
    word(2'd0, 32'hFFFFFFFF, 32'h1, 32'hFFFFFFFF, 32'h1,
         32'h0, 32'h0, 2'b11, 2'b11, 1'b1);
    chk("gap_finish_count", 32'(nfinish - f0), 32'd1);

    f0 = nfinish;
    do_start(2'd0);
    send(32'h11111111, 32'h22222222,
         32'h11111111, 32'h22222222,
         32'h33333333, 32'h33333333, 2'b00, 2'b00, 4, 1'b0);
    start = 1'b1;
    op = 2'd0;
    in_valid = 1'b1;
    serial_data_in = pack(32'h11111111, 32'h22222222,
                          32'h11111111, 32'h22222222, 4);
    step();
    start = 1'b0;
    chk("abort_drop_slice", 32'(out_valid), 32'd0);
    send(32'd3, 32'd4, 32'd3, 32'd4,
         32'd7, 32'd7, 2'b00, 2'b00, 8, 1'b0);
    drain();
    step();
    chk("abort_finish_count", 32'(nfinish - f0), 32'd1);

    do_start(2'd0);
    send(32'h11111111, 32'h22222222,
         32'h11111111, 32'h22222222,
         32'h33333333, 32'h33333333, 2'b00, 2'b00, 3, 1'b0);
    reset = 1'b1;
    in_valid = 1'b1;
    serial_data_in = pack(32'h11111111, 32'h22222222,
                          32'h11111111, 32'h22222222, 3);
    step();
    reset = 1'b0;
    all_zero("midreset");
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      serial_data_in = 16'h1234;
      step();
      chk("noStart_ovalid", 32'(out_valid), 32'd0);
    end
    in_valid = 1'b0;
    step();
    chk("final_queue", 32'(q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
